// File: rtl/adma_dm_rd_sched_if.sv
// Request/transaction bundle between the per-channel splitters, the read scheduler and the read host.
// The scheduler takes the master view: it owns req_rdy, chn_busy and the atx_* payload.
interface adma_dm_rd_sched_if #(
   parameter int DMA_CHN_NUM   = 4,
   parameter int SRC_ADDR_W    = 32,
   parameter int MST_ID_W      = 5,
   parameter int ATX_LEN_W     = 8,
   parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
);
   logic [DMA_CHN_NUM-1:0][MST_ID_W-1:0]   req_arid;
   logic [DMA_CHN_NUM-1:0][SRC_ADDR_W-1:0] req_araddr;
   logic [DMA_CHN_NUM-1:0][ATX_LEN_W-1:0]  req_arlen;
   logic [DMA_CHN_NUM-1:0][1:0]            req_arburst;
   logic [DMA_CHN_NUM-1:0]                 req_vld;
   logic [DMA_CHN_NUM-1:0]                 req_rdy;
   logic [DMA_CHN_NUM-1:0]                 cpl_vld;
   logic [DMA_CHN_NUM_W-1:0]               atx_chn_id;
   logic [MST_ID_W-1:0]                    atx_arid;
   logic [SRC_ADDR_W-1:0]                  atx_araddr;
   logic [ATX_LEN_W-1:0]                   atx_arlen;
   logic [1:0]                             atx_arburst;
   logic                                   atx_vld;
   logic                                   atx_rdy;
   logic [DMA_CHN_NUM-1:0]                 chn_busy;

   modport master (
      input  req_arid, req_araddr, req_arlen, req_arburst, req_vld, cpl_vld, atx_rdy,
      output req_rdy, atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst, atx_vld, chn_busy
   );

   modport slave (
      output req_arid, req_araddr, req_arlen, req_arburst, req_vld, cpl_vld, atx_rdy,
      input  req_rdy, atx_chn_id, atx_arid, atx_araddr, atx_arlen, atx_arburst, atx_vld, chn_busy
   );
endinterface

// File: rtl/adma_dm_rd_sched.sv
// Round-robin read-transaction scheduler: shares one read host between DMA channels while
// bounding per-channel and global outstanding transactions, with one registered output slot.
module adma_dm_rd_sched #(
   parameter int DMA_CHN_NUM   = 4,
   parameter int SRC_ADDR_W    = 32,
   parameter int MST_ID_W      = 5,
   parameter int ATX_LEN_W     = 8,
   parameter int ATX_NUM_OSTD  = DMA_CHN_NUM,
   parameter int CHN_OSTD_MAX  = 2,
   parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   adma_dm_rd_sched_if.master rd
);
   localparam int N  = DMA_CHN_NUM;
   localparam int CW = $clog2(CHN_OSTD_MAX + 1);
   localparam int GW = $clog2(ATX_NUM_OSTD + 1);

   logic [N-1:0][CW-1:0]     ostd_cnt_q, ostd_cnt_d;
   logic [GW-1:0]            glb_cnt_q, glb_cnt_d;
   logic [DMA_CHN_NUM_W-1:0] rr_ptr_q, rr_ptr_d;
   logic                     atx_vld_q, atx_vld_d;
   logic [DMA_CHN_NUM_W-1:0] chn_id_q, chn_id_d;
   logic [MST_ID_W-1:0]      arid_q, arid_d;
   logic [SRC_ADDR_W-1:0]    araddr_q, araddr_d;
   logic [ATX_LEN_W-1:0]     arlen_q, arlen_d;
   logic [1:0]               arburst_q, arburst_d;

   logic                     slot_free;
   logic                     glb_ok;
   logic                     gnt_any;
   logic [N-1:0]             cpl_eff;
   logic [N-1:0]             elig;
   logic [N-1:0]             grant;
   logic [GW-1:0]            cpl_num;
   logic [DMA_CHN_NUM_W-1:0] gnt_idx;
   logic [DMA_CHN_NUM_W-1:0] cand;

   assign slot_free = !atx_vld_q || rd.atx_rdy;

   // Completions on idle channels are dropped; the rest return credit in the same cycle.
   always_comb begin
      cpl_eff = '0;
      cpl_num = '0;
      for (int i = 0; i < N; i++) begin
         cpl_eff[i] = rd.cpl_vld[i] && (ostd_cnt_q[i] != '0);
         cpl_num    = cpl_num + GW'(cpl_eff[i]);
      end
   end

   assign glb_ok = (glb_cnt_q - cpl_num) < GW'(ATX_NUM_OSTD);

   always_comb begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
         elig[i] = rst_n && rd.req_vld[i] && slot_free && glb_ok &&
                   ((ostd_cnt_q[i] - CW'(cpl_eff[i])) < CW'(CHN_OSTD_MAX));
      end
   end

   always_comb begin
      int idx;
      idx     = 0;
      cand    = '0;
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N) idx = idx - N;
         cand = DMA_CHN_NUM_W'(idx);
         if (!gnt_any && elig[cand]) begin
            gnt_any     = 1'b1;
            gnt_idx     = cand;
            grant[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      ostd_cnt_d = ostd_cnt_q;
      glb_cnt_d  = glb_cnt_q - cpl_num + GW'(gnt_any);
      rr_ptr_d   = rr_ptr_q;
      atx_vld_d  = atx_vld_q;
      chn_id_d   = chn_id_q;
      arid_d     = arid_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arburst_d  = arburst_q;
      for (int i = 0; i < N; i++) begin
         ostd_cnt_d[i] = ostd_cnt_q[i] + CW'(grant[i]) - CW'(cpl_eff[i]);
      end
      if (slot_free) begin
         atx_vld_d = gnt_any;
         if (gnt_any) begin
            rr_ptr_d  = (gnt_idx == DMA_CHN_NUM_W'(N - 1)) ? '0 : gnt_idx + DMA_CHN_NUM_W'(1);
            chn_id_d  = gnt_idx;
            arid_d    = rd.req_arid[gnt_idx];
            araddr_d  = rd.req_araddr[gnt_idx];
            arlen_d   = rd.req_arlen[gnt_idx];
            arburst_d = rd.req_arburst[gnt_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ostd_cnt_q <= '0;
         glb_cnt_q  <= '0;
         rr_ptr_q   <= '0;
         atx_vld_q  <= 1'b0;
         chn_id_q   <= '0;
         arid_q     <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arburst_q  <= '0;
      end else begin
         ostd_cnt_q <= ostd_cnt_d;
         glb_cnt_q  <= glb_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
         atx_vld_q  <= atx_vld_d;
         chn_id_q   <= chn_id_d;
         arid_q     <= arid_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arburst_q  <= arburst_d;
      end
   end

   always_comb begin
      rd.chn_busy = '0;
      for (int i = 0; i < N; i++) begin
         rd.chn_busy[i] = (ostd_cnt_q[i] != '0);
      end
   end

   assign rd.req_rdy     = grant;
   assign rd.atx_vld     = atx_vld_q;
   assign rd.atx_chn_id  = chn_id_q;
   assign rd.atx_arid    = arid_q;
   assign rd.atx_araddr  = araddr_q;
   assign rd.atx_arlen   = arlen_q;
   assign rd.atx_arburst = arburst_q;
endmodule

// File: doc/adma_dm_rd_sched.md
# adma_dm_rd_sched

Read-transaction scheduler for the DMA data mover. It shares the single read host (AR issue + R return path) between `DMA_CHN_NUM` channels using round-robin arbitration. It enforces a per-channel and a global outstanding-transaction limit, then presents one registered transaction at a time on the host's `atx_*` handshake. It sits between the per-channel descriptor/burst splitters and the read host.

## Interface
- `DMA_CHN_NUM`, 4, number of requesting channels
- `SRC_ADDR_W`, 32, AR address width
- `MST_ID_W`, 5, AXI ID width
- `ATX_LEN_W`, 8, AR length width
- `ATX_NUM_OSTD`, `DMA_CHN_NUM`, global outstanding limit (≥1)
- `CHN_OSTD_MAX`, 2, per-channel outstanding limit (≥1)
- `DMA_CHN_NUM_W`, `(DMA_CHN_NUM>1)?$clog2(DMA_CHN_NUM):1`, derived
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `req_arid` in `MST_ID_W` ×N — per-channel ID
- `req_araddr` in `SRC_ADDR_W` ×N — per-channel address
- `req_arlen` in `ATX_LEN_W` ×N — per-channel length
- `req_arburst` in 2 ×N — per-channel burst type
- `req_vld` in 1 ×N — channel request valid
- `req_rdy` out 1 ×N — channel request accepted (grant)
- `cpl_vld` in 1 ×N — one-cycle pulse: one transaction of channel i fully returned
- `atx_chn_id` out `DMA_CHN_NUM_W` — granted channel
- `atx_arid`, `atx_araddr`, `atx_arlen`, `atx_arburst` out — registered payload
- `atx_vld` out 1 — payload valid to read host
- `atx_rdy` in 1 — read host ready
- `chn_busy` out 1 ×N — channel has ≥1 outstanding transaction

## Operation
- Output slot: one register stage holding payload + `atx_chn_id`. The slot is free when `!atx_vld || atx_rdy`.
- Eligibility of channel i: `req_vld[i]`, `ostd_cnt[i] < CHN_OSTD_MAX`, and `glb_cnt < ATX_NUM_OSTD`.
- Arbitration happens each cycle the slot is free. It is round-robin: priority starts at `rr_ptr` and wraps modulo N. The first eligible channel g gets `req_rdy[g]=1` combinationally; all other `req_rdy` are 0.
- On grant:
  - slot loads channel g's payload and `atx_vld` is 1 next cycle;
  - `rr_ptr ← (g+1) mod N`;
  - `ostd_cnt[g]` and `glb_cnt` increment.
- No eligible channel while the slot is free: `atx_vld` goes 0, `rr_ptr` is unchanged.
- `cpl_vld[i]` decrements `ostd_cnt[i]` and `glb_cnt`. A grant and a completion on the same channel in the same cycle leave the count unchanged. `glb_cnt` sums all grants and completions in the cycle (net change −N..+1).
- `cpl_vld[i]` with `ostd_cnt[i]==0` is ignored; the counter stays 0 (no underflow).
- Counter widths: `$clog2(CHN_OSTD_MAX+1)` and `$clog2(ATX_NUM_OSTD+1)`. Counters never exceed their limits.
- `chn_busy[i] = (ostd_cnt[i] != 0)`.
- Accounting counts a transaction as outstanding from grant, not from AR acceptance. This guarantees the read host's reorder/ID tracking never sees more than `ATX_NUM_OSTD` transactions.

## Timing
- Reset values: `atx_vld`=0; all payload and `atx_chn_id` = 0; all counters 0; `rr_ptr`=0. `req_rdy` is 0 in reset because `req_vld` is masked.
- Latency: request accepted in cycle T → `atx_vld`=1 with that payload in T+1.
- Throughput: one grant per cycle while `atx_rdy`=1 and eligibility holds.
- Backpressure: while `atx_vld && !atx_rdy`, payload and `atx_chn_id` are held stable, and all `req_rdy` are 0.
- Handshakes: `atx_vld` never drops without `atx_rdy`. `req_rdy` may depend combinationally on `req_vld`, `atx_rdy` and `cpl_vld`. `atx_vld` depends only on registers.
- A completion in cycle T frees credit for arbitration in cycle T (same-cycle reuse).
- Asynchronous reset mid-operation: all state clears immediately. Any granted transaction not yet taken by the host is discarded. Upstream re-issues after reset.

## Test plan
- Single channel, N=4, ch2 requests `araddr=0x1000, arlen=7, arid=3` with `atx_rdy=1` → `req_rdy[2]` in T; `atx_vld`, `atx_chn_id=2`, payload matching in T+1; `chn_busy[2]=1` until `cpl_vld[2]`.
- All 4 channels request continuously, `CHN_OSTD_MAX=4`, `ATX_NUM_OSTD=8` → grant order 0,1,2,3,0,1,2,3, one per cycle; stall after 8 grants until a `cpl_vld`.
- `atx_rdy=0` for 5 cycles with `atx_vld=1` → payload stable, all `req_rdy`=0; on `atx_rdy=1`, next RR channel granted the same cycle.
- `CHN_OSTD_MAX=2`, ch0 only: 2 grants then `req_rdy[0]`=0. `cpl_vld[0]` pulse → third grant in the same cycle. Grant plus completion in one cycle → `ostd_cnt[0]` stays 2.
- `cpl_vld[1]` with `ostd_cnt[1]=0` → no counter change, `glb_cnt` unchanged, `chn_busy[1]`=0.
- Assert `rst_n`=0 asynchronously while `atx_vld=1` and counters are nonzero → `atx_vld`, `chn_busy`, payload read 0 before the next edge. After release, the first grant goes to the lowest-index requester.
